// File: rtl/signed_accumulator.sv
// Signed accumulator with a valid/ready operand port and a three-state
// sequencer. Applies LOAD/ADD/SUB/CLEAR at ACC_WIDTH+1 bits, then wraps or clamps.
module signed_accumulator #(
   parameter int WIDTH     = 4,
   parameter int ACC_WIDTH = 8,
   parameter bit SATURATE  = 1'b0
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 op_valid,
   output logic                 op_ready,
   input  logic [1:0]           op_code,
   input  logic [WIDTH-1:0]     operand,
   output logic [ACC_WIDTH-1:0] acc,
   output logic                 res_valid,
   output logic                 overflow,
   output logic [7:0]           op_count
);

   localparam int RW = ACC_WIDTH + 1;

   typedef enum logic [1:0] {IDLE, COMPUTE, WRITE} state_t;
   typedef enum logic [1:0] {OP_LOAD = 2'b00, OP_ADD = 2'b01, OP_SUB = 2'b10, OP_CLEAR = 2'b11} op_t;

   localparam logic [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
   localparam logic [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

   state_t               state_q, state_d;
   op_t                  op_q, op_d;
   logic [WIDTH-1:0]     operand_q, operand_d;
   logic [RW-1:0]        result_q, result_d;
   logic [ACC_WIDTH-1:0] acc_q, acc_d;
   logic                 ovf_q, ovf_d;
   logic                 res_valid_q, res_valid_d;
   logic [7:0]           count_q, count_d;

   logic [RW-1:0]        operand_ext;
   logic [RW-1:0]        acc_ext;
   logic                 ovf_now;

   assign operand_ext = {{(RW-WIDTH){operand_q[WIDTH-1]}}, operand_q};
   assign acc_ext     = {acc_q[ACC_WIDTH-1], acc_q};

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path can infer a latch.
      state_d     = state_q;
      op_d        = op_q;
      operand_d   = operand_q;
      result_d    = result_q;
      acc_d       = acc_q;
      ovf_d       = ovf_q;
      res_valid_d = 1'b0;
      count_d     = count_q;
      ovf_now     = 1'b0;
      op_ready    = (state_q == IDLE);

      case (state_q)
         IDLE: begin
            if (op_valid) begin
               op_d      = op_t'(op_code);
               operand_d = operand;
               count_d   = count_q + 8'd1;
               state_d   = COMPUTE;
            end
         end
         COMPUTE: begin
            case (op_q)
               OP_LOAD:  result_d = operand_ext;
               OP_ADD:   result_d = acc_ext + operand_ext;
               OP_SUB:   result_d = acc_ext - operand_ext;
               default:  result_d = '0;
            endcase
            state_d = WRITE;
         end
         WRITE: begin
            // The extra result bit holds the true sign; a mismatch with the
            // accumulator's sign bit means the value does not fit.
            ovf_now = ((op_q == OP_ADD) || (op_q == OP_SUB)) &&
                      (result_q[RW-1] != result_q[RW-2]);
            if (SATURATE && ovf_now)
               acc_d = result_q[RW-1] ? ACC_MIN : ACC_MAX;
            else
               acc_d = result_q[ACC_WIDTH-1:0];
            if (op_q == OP_CLEAR)
               ovf_d = 1'b0;
            else if (ovf_now)
               ovf_d = 1'b1;
            res_valid_d = 1'b1;
            state_d     = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: state registers use non-blocking assignments so all flops update together.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= IDLE;
         op_q        <= OP_LOAD;
         operand_q   <= '0;
         result_q    <= '0;
         acc_q       <= '0;
         ovf_q       <= 1'b0;
         res_valid_q <= 1'b0;
         count_q     <= '0;
      end else begin
         state_q     <= state_d;
         op_q        <= op_d;
         operand_q   <= operand_d;
         result_q    <= result_d;
         acc_q       <= acc_d;
         ovf_q       <= ovf_d;
         res_valid_q <= res_valid_d;
         count_q     <= count_d;
      end
   end

   assign acc       = acc_q;
   assign res_valid = res_valid_q;
   assign overflow  = ovf_q;
   assign op_count  = count_q;

endmodule

// File: doc/signed_accumulator.md
Name: signed_accumulator

Overview:
Parametrised signed accumulator, the successor to the board's combinational 4-bit signed adder. Accepts a stream of signed operands through a valid/ready handshake and applies LOAD, ADD, SUB or CLEAR to a wider registered accumulator. Detects signed overflow, with selectable wrap or saturate mode. Sits in the board top between the switch inputs and the 7-segment/LED outputs; it is the core of the running-total lab exercise.

Parameters:
WIDTH, 4, operand width in bits (two's complement), >= 2
ACC_WIDTH, 8, accumulator width in bits, >= WIDTH
SATURATE, 0, 0 = wrap on overflow, 1 = clamp to the most positive/negative ACC_WIDTH value

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
op_valid  input  1  operation request
op_ready  output  1  block can accept an operation this cycle
op_code  input  2  00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
operand  input  WIDTH  signed operand, sampled on accept
acc  output  ACC_WIDTH  signed accumulator value, registered
res_valid  output  1  one-cycle pulse when acc is updated by an operation
overflow  output  1  sticky signed-overflow flag
op_count  output  8  number of accepted operations, wraps 255 -> 0

Behaviour:
- reset low (async): acc=0, overflow=0, res_valid=0, op_count=0, FSM=IDLE, op_ready=1. Outputs hold these values while reset is low.
- FSM has three states: IDLE, COMPUTE, WRITE.
- IDLE: op_ready=1.
  - Accept = op_valid & op_ready at a rising edge.
  - On accept: latch op_code and operand, increment op_count, go to COMPUTE.
- COMPUTE: op_ready=0.
  - Sign-extend operand to ACC_WIDTH+1 bits and form the ACC_WIDTH+1-bit result:
    - LOAD: sext(operand)
    - ADD: sext(acc) + sext(operand)
    - SUB: sext(acc) - sext(operand)
    - CLEAR: 0
  - Register the result internally, then go to WRITE.
- WRITE: op_ready=0.
  - Overflow condition: result bit ACC_WIDTH differs from bit ACC_WIDTH-1 (ADD/SUB only; LOAD and CLEAR never overflow).
  - SATURATE=0: acc <= result[ACC_WIDTH-1:0].
  - SATURATE=1: on overflow, acc <= max positive if the result is positive, or min negative if the result is negative; otherwise acc <= result[ACC_WIDTH-1:0].
  - overflow <= 1 on overflow; it stays set until CLEAR or reset. LOAD does not clear it.
  - res_valid=1 for exactly this cycle's update; acc and res_valid change at the same edge. Then go to IDLE.
- Latency: accept at edge N; acc and res_valid are updated at edge N+2; op_ready returns high after edge N+2. Maximum throughput is one operation every 3 cycles.
- op_valid asserted while op_ready=0 is ignored; no queueing. The requester holds op_valid, op_code and operand until accepted.
- Changes to op_code or operand after accept have no effect on the operation in flight.
- SUB of the most negative operand (e.g. -8 for WIDTH=4) is exact, because the arithmetic is ACC_WIDTH+1 bits wide.
- Reset asserted in COMPUTE or WRITE aborts the operation: no res_valid pulse, all state returns to reset values.
- op_count wraps from 255 to 0 without a flag.

Test Plan:
- Reset: hold reset low 3 cycles, then release -> acc=0x00, overflow=0, op_ready=1, op_count=0, res_valid never pulses.
- LOAD operand 4'b1101 (-3) accepted at edge N -> op_ready=0 at N+1 and N+2; acc=0xFD and res_valid=1 exactly at N+2; op_count=1.
- SATURATE=0: LOAD 0, then ADD 7 nineteen times -> after the 18th ADD acc=0x7E (126), overflow=0; after the 19th acc=0x85 (-123), overflow=1 and stays 1 through a following LOAD 2 (acc=0x02).
- SATURATE=1, same sequence -> 19th ADD gives acc=0x7F, overflow=1. Then LOAD -8 and SUB 7 nineteen times -> acc clamps at 0x80.
- SUB operand -8 from acc=0 (SATURATE=0) -> acc=0x08, overflow=0. CLEAR with overflow=1 -> acc=0x00, overflow=0.
- op_valid held high for 10 cycles with ADD 1 -> exactly 4 accepts (edges 0, 3, 6, 9) and acc=0x03 after edge 8. Reset pulse at the edge after an accept -> no res_valid, acc=0x00, op_count=0.
